// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS LSB-first, optional parity, 1-2 stop bits.
// All outputs are registered; a two-process FSM computes the next value of every register.
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 278,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int CW           = $clog2(CLKS_PER_BIT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DATA_BITS-1:0] data_tx,
    output logic                 rdy,
    output logic                 dout,
    output logic [2:0]           state,
    output logic [3:0]           index,
    output logic [CW-1:0]        counter
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    state_t               r_state, w_state;
    logic [DATA_BITS-1:0] r_shift, w_shift;
    logic                 r_par, w_par;
    logic                 r_dout, w_dout;
    logic                 r_rdy, w_rdy;
    logic [3:0]           r_index, w_index;
    logic [CW-1:0]        r_counter, w_counter;
    logic                 w_bit_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_dout    <= 1'b1;
            r_rdy     <= 1'b1;
            r_index   <= '0;
            r_counter <= '0;
        end else begin
            r_state   <= w_state;
            r_shift   <= w_shift;
            r_par     <= w_par;
            r_dout    <= w_dout;
            r_rdy     <= w_rdy;
            r_index   <= w_index;
            r_counter <= w_counter;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_shift   = r_shift;
        w_par     = r_par;
        w_dout    = r_dout;
        w_rdy     = r_rdy;
        w_index   = r_index;
        w_bit_end = (r_counter == LAST_CNT);
        w_counter = w_bit_end ? '0 : r_counter + 1'b1;

        case (r_state)
            S_IDLE: begin
                w_counter = '0;
                if (en) begin
                    w_shift = data_tx;
                    w_par   = (PARITY == 1) ? ~^data_tx : ^data_tx;
                    w_rdy   = 1'b0;
                    w_dout  = 1'b0;
                    w_index = '0;
                    w_state = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state = S_DATA;
                    w_dout  = r_shift[0];
                    w_shift = r_shift >> 1;
                    w_index = '0;
                end
            end
            S_DATA: begin
                // The shift register always presents the next data bit at bit 0.
                if (w_bit_end) begin
                    if (r_index == LAST_DATA) begin
                        if (PARITY != 0) begin
                            w_state = S_PARITY;
                            w_dout  = r_par;
                        end else begin
                            w_state = S_STOP;
                            w_dout  = 1'b1;
                            w_index = '0;
                        end
                    end else begin
                        w_index = r_index + 4'd1;
                        w_dout  = r_shift[0];
                        w_shift = r_shift >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state = S_STOP;
                    w_dout  = 1'b1;
                    w_index = '0;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_index == LAST_STOP) begin
                        w_state = S_IDLE;
                        w_rdy   = 1'b1;
                        w_index = '0;
                    end else begin
                        w_index = r_index + 4'd1;
                    end
                end
            end
            default: begin
                w_state   = S_IDLE;
                w_rdy     = 1'b1;
                w_dout    = 1'b1;
                w_index   = '0;
                w_counter = '0;
            end
        endcase
    end

    assign rdy     = r_rdy;
    assign dout    = r_dout;
    assign state   = r_state;
    assign index   = r_index;
    assign counter = r_counter;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four parameterisations share one clock; a queue of expected
// per-bit line value/state/index is filled at each accept and drained bit by bit as the frame goes out.
module tb_uart_tx_param;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] data_tx;
    logic [1:0] sel;
    logic [3:0] en_v;

    logic [3:0] rdy_v, dout_v;
    logic [2:0] st_v [4];
    logic [3:0] ix_v [4];
    logic [1:0] cn_v [4];

    logic       w_rdy, w_dout;
    logic [2:0] w_state;
    logic [3:0] w_index;
    logic [1:0] w_cnt;

    typedef struct packed {
        logic       b;
        logic [2:0] st;
        logic [3:0] ix;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   fails   = 0;

    assign en_v = en ? (4'b0001 << sel) : 4'b0000;

    always_comb begin
        w_rdy   = rdy_v[sel];
        w_dout  = dout_v[sel];
        w_state = st_v[sel];
        w_index = ix_v[sel];
        w_cnt   = cn_v[sel];
    end

    uart_tx_param #(.CLKS_PER_BIT(CPB)) u_8n1 (
        .clk(clk), .rst(rst), .en(en_v[0]), .data_tx(data_tx),
        .rdy(rdy_v[0]), .dout(dout_v[0]), .state(st_v[0]), .index(ix_v[0]), .counter(cn_v[0])
    );
    uart_tx_param #(.CLKS_PER_BIT(CPB), .PARITY(2)) u_even (
        .clk(clk), .rst(rst), .en(en_v[1]), .data_tx(data_tx),
        .rdy(rdy_v[1]), .dout(dout_v[1]), .state(st_v[1]), .index(ix_v[1]), .counter(cn_v[1])
    );
    uart_tx_param #(.CLKS_PER_BIT(CPB), .PARITY(1)) u_odd (
        .clk(clk), .rst(rst), .en(en_v[2]), .data_tx(data_tx),
        .rdy(rdy_v[2]), .dout(dout_v[2]), .state(st_v[2]), .index(ix_v[2]), .counter(cn_v[2])
    );
    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst(rst), .en(en_v[3]), .data_tx(data_tx[6:0]),
        .rdy(rdy_v[3]), .dout(dout_v[3]), .state(st_v[3]), .index(ix_v[3]), .counter(cn_v[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s @%0t sel=%0d observed=%0h expected=%0h", tag, $time, sel, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".rdy"},     w_rdy,   1);
        chk({tag, ".dout"},    w_dout,  1);
        chk({tag, ".state"},   w_state, 0);
        chk({tag, ".index"},   w_index, 0);
        chk({tag, ".counter"}, w_cnt,   0);
    endtask

    // Expected frame built from the word being sent: start, data LSB-first, parity, stops.
    task automatic push_frame(input logic [7:0] d, input int db, input int par, input int sb);
        int   ones;
        logic pb;
        ones = 0;
        q.push_back('{b: 1'b0, st: 3'd1, ix: 4'd0});
        for (int i = 0; i < db; i++) begin
            q.push_back('{b: d[i], st: 3'd2, ix: 4'(i)});
            ones += int'(d[i]);
        end
        if (par != 0) begin
            pb = (par == 2) ? ones[0] : ~ones[0];
            q.push_back('{b: pb, st: 3'd3, ix: 4'd0});
        end
        for (int j = 0; j < sb; j++)
            q.push_back('{b: 1'b1, st: 3'd4, ix: 4'(j)});
    endtask

    task automatic accept(input logic [7:0] d, input int db, input int par, input int sb);
        data_tx = d;
        en      = 1'b1;
        push_frame(d, db, par, sb);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic body(input int poke, input bit hold);
        exp_t e;
        int   k;
        k = 0;
        if (!hold) en = 1'b0;
        while (q.size() != 0) begin
            e = q.pop_front();
            for (int c = 0; c < CPB; c++) begin
                chk("frame.dout",  w_dout,  e.b);
                chk("frame.state", w_state, e.st);
                if (e.st != 3'd3) chk("frame.index", w_index, e.ix);
                chk("frame.counter", w_cnt, c);
                chk("frame.rdy",     w_rdy, 0);
                if (poke >= 0 && k == poke) begin
                    en      = 1'b1;
                    data_tx = 8'h00;
                end
                if (poke >= 0 && k == poke + 1) en = 1'b0;
                k++;
                @(negedge clk);
            end
        end
        chk_idle("end");
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        data_tx = 8'h00;
        sel     = 2'd0;

        // Reset and idle
        repeat (2) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            chk_idle("reset");
        end
        rst = 1'b0;
        sel = 2'd0;
        repeat (3) begin
            @(negedge clk);
            chk_idle("idle");
        end

        // 8N1 0x55
        accept(8'h55, 8, 0, 1);
        body(-1, 1'b0);

        // Even and odd parity on 0x07
        @(negedge clk);
        sel = 2'd1;
        accept(8'h07, 8, 2, 1);
        body(-1, 1'b0);
        @(negedge clk);
        sel = 2'd2;
        accept(8'h07, 8, 1, 1);
        body(-1, 1'b0);

        // 7 data bits, 2 stop bits
        @(negedge clk);
        sel = 2'd3;
        accept(8'h7F, 7, 0, 2);
        body(-1, 1'b0);

        // Busy request mid-frame is ignored
        @(negedge clk);
        sel = 2'd0;
        accept(8'hA5, 8, 0, 1);
        body(13, 1'b0);
        @(negedge clk);
        chk_idle("after_poke");

        // Back-to-back with en held: exactly one idle-high cycle between frames
        accept(8'h3C, 8, 0, 1);
        body(-1, 1'b1);
        accept(8'hC3, 8, 0, 1);
        body(-1, 1'b1);
        en = 1'b0;
        @(negedge clk);
        chk_idle("after_b2b");

        // Reset during DATA bit 3
        accept(8'hC5, 8, 0, 1);
        en = 1'b0;
        q.delete();
        repeat (17) @(negedge clk);
        chk("midrst.state", w_state, 2);
        chk("midrst.index", w_index, 3);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("midrst");
        rst = 1'b0;
        accept(8'hC5, 8, 0, 1);
        body(-1, 1'b0);

        // Reset wins over simultaneous en
        rst = 1'b1;
        en  = 1'b1;
        @(negedge clk);
        chk_idle("rst_en");
        rst = 1'b0;
        en  = 1'b0;
        @(negedge clk);
        chk_idle("rst_en_after");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised UART transmitter and successor to the fixed 8N1 Transmitter.
- Serialises one parallel word per start strobe onto `dout`, in the order: start bit, data bits LSB-first, optional parity bit, 1 or 2 stop bits.
- Baud timing is derived from the system clock (32 MHz in the lab setup) by a per-bit cycle counter.
- Exposes `rdy` for the host handshake, plus `state`, `index` and `counter` debug outputs for bench visibility.

Parameters:
- CLKS_PER_BIT, 278, clock cycles per serial bit (32 MHz / 115200); legal range >= 2.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; 1 or 2.
- CW, $clog2(CLKS_PER_BIT), width of `counter`.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  start request; sampled only while `rdy`=1.
- data_tx  in  DATA_BITS  word to send; latched when the request is accepted.
- rdy  out  1  1 = idle and able to accept `en`.
- dout  out  1  serial line; idle high; registered output.
- state  out  3  FSM state: 0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP.
- index  out  4  current data-bit index, or stop-bit index in STOP.
- counter  out  CW  cycle count within the current bit, 0..CLKS_PER_BIT-1.

Behaviour:
- Reset (`rst`=1 at an edge): `state`=IDLE, `dout`=1, `rdy`=1, `index`=0, `counter`=0, shift register cleared. Reset overrides everything, including mid-frame; the line returns high on that same edge.
- IDLE, `en`=1 at edge N:
  - latch `data_tx` into the shift register and compute the parity bit;
  - set `rdy`=0, `dout`=0, `state`=START, `counter`=0.
  - Latency: `dout` is low from edge N onward (one-edge start latency).
- IDLE, `en`=0: hold all outputs at their reset values.
- Bit timing:
  - `counter` increments every cycle.
  - When `counter` = CLKS_PER_BIT-1, the next edge sets `counter`=0 and advances to the next bit.
  - Every bit holds `dout` for exactly CLKS_PER_BIT cycles.
- START -> DATA: `dout` = data[0], `index`=0.
- DATA:
  - On each bit boundary, `index`++ and `dout` = data[index].
  - After bit DATA_BITS-1, go to PARITY if PARITY != 0, else STOP.
- PARITY:
  - `dout` = XOR of the latched data when even (PARITY=2).
  - `dout` = inverted XOR of the latched data when odd (PARITY=1).
  - Then go to STOP.
- STOP:
  - `dout`=1; `index` counts stop bits from 0.
  - After the last cycle of the last stop bit: `state`=IDLE, `rdy`=1, `index`=0 on that edge.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) × CLKS_PER_BIT cycles, from the accept edge to the edge where `rdy` returns to 1.
- While `rdy`=0:
  - `en` is ignored, with no queuing;
  - `data_tx` changes have no effect on the frame in flight.
- Back-to-back: if `en` is held high, a new frame is accepted on the first edge after `rdy` returns to 1. The line is high for exactly 1 cycle beyond the stop bit(s).
- Simultaneous `rst` and `en`: reset wins; no frame starts.
- `rdy` never glitches: it is 0 for the entire frame, including the final stop cycle.

Test Plan:
1. Reset check, CLKS_PER_BIT=4, defaults: assert `rst` for 2 cycles -> `dout`=1, `rdy`=1, `state`=0, `counter`=0 while `en`=0.
2. 8N1 frame, CLKS_PER_BIT=4, `data_tx`=0x55, 1-cycle `en` pulse:
   - `dout` sequence per 4-cycle bit = 0,1,0,1,0,1,0,1,0,1;
   - `rdy` low for exactly 40 cycles.
3. Parity, PARITY=2 (even), `data_tx`=0x07: parity bit = 1. With PARITY=1 (odd), same data: parity bit = 0. Frame = 11 bits.
4. 7 data bits, 2 stop bits, `data_tx`=0x7F:
   - 7 ones after the start bit, then 2 high stop bits;
   - `rdy` low for 10 × CLKS_PER_BIT cycles;
   - `index` reaches 1 in STOP.
5. Busy and back-to-back, CLKS_PER_BIT=4:
   - Pulse `en` mid-frame with `data_tx`=0x00 -> ignored; the frame in flight is unchanged.
   - Hold `en`=1 continuously -> consecutive frames separated by exactly one idle-high cycle.
6. Reset mid-frame: assert `rst` during DATA bit 3 -> next edge `dout`=1, `rdy`=1, `state`=0. A new `en` then sends a complete, correct frame.
